// File: rtl/show_glyph_overlay.sv
// Purpose: stamps up to N_SLOT glyphs from an external 1-bit ROM onto an RGB888 pixel stream.
// Latency: 5 clocks from i_valid/i_data to o_valid/o_data. The ROM read sits in stages S3/S4.
// Backpressure: none. The pipeline moves every clock, and bubbles travel through as valid=0.
module show_glyph_overlay #(
  parameter int          P_W       = 12,
  parameter int          IMG_W     = 1024,
  parameter int          IMG_H     = 768,
  parameter int          N_SLOT    = 8,
  parameter int          GLYPH_W   = 32,
  parameter int          GLYPH_H   = 64,
  parameter int          GLYPH_NUM = 8,
  parameter logic [23:0] FG_COLOR  = 24'hFF0000,
  parameter logic [23:0] BG_COLOR  = 24'hFFFFFF
) (
  input  logic                                             sys_clk,
  input  logic                                             sys_rst_n,
  input  logic                                             i_valid,
  input  logic                                             i_sof,
  input  logic [23:0]                                      i_data,
  input  logic                                             cfg_we,
  input  logic [$clog2(N_SLOT)-1:0]                        cfg_slot,
  input  logic                                             cfg_en,
  input  logic                                             cfg_mode,
  input  logic [$clog2(GLYPH_NUM)-1:0]                     cfg_glyph,
  input  logic [P_W-1:0]                                   cfg_x,
  input  logic [P_W-1:0]                                   cfg_y,
  output logic [$clog2(GLYPH_NUM*GLYPH_W*GLYPH_H)-1:0]     o_rom_ad,
  input  logic                                             i_rom_bit,
  output logic                                             o_valid,
  output logic [23:0]                                      o_data
);
  localparam int GW = $clog2(GLYPH_NUM);
  localparam int XW = $clog2(GLYPH_W);
  localparam int YW = $clog2(GLYPH_H);
  localparam logic [P_W-1:0] X_LAST = P_W'(IMG_W - 1);
  localparam logic [P_W-1:0] Y_LAST = P_W'(IMG_H - 1);
  localparam logic [P_W:0]   GW_EXT = (P_W+1)'(GLYPH_W);
  localparam logic [P_W:0]   GH_EXT = (P_W+1)'(GLYPH_H);

  logic [P_W-1:0] x_cnt, y_cnt, px, py;
  logic           frame_bnd;

  logic [N_SLOT-1:0] sh_en, sh_mode, act_en, act_mode;
  logic [GW-1:0]     sh_glyph [N_SLOT];
  logic [GW-1:0]     act_glyph [N_SLOT];
  logic [P_W-1:0]    sh_x [N_SLOT];
  logic [P_W-1:0]    sh_y [N_SLOT];
  logic [P_W-1:0]    act_x [N_SLOT];
  logic [P_W-1:0]    act_y [N_SLOT];

  logic          hit, hit_mode;
  logic [GW-1:0] hit_glyph;
  logic [XW-1:0] hit_dx;
  logic [YW-1:0] hit_dy;

  logic          s1_vld, s1_hit, s1_mode;
  logic [23:0]   s1_dat;
  logic [GW-1:0] s1_glyph;
  logic [XW-1:0] s1_dx;
  logic [YW-1:0] s1_dy;
  logic          s2_vld, s2_hit, s2_mode;
  logic [23:0]   s2_dat;
  logic          s3_vld, s3_hit, s3_mode;
  logic [23:0]   s3_dat;
  logic          s4_vld, s4_hit, s4_mode;
  logic [23:0]   s4_dat;

  // A start-of-frame pixel is (0,0) no matter where the counters had got to.
  assign px        = i_sof ? '0 : x_cnt;
  assign py        = i_sof ? '0 : y_cnt;
  assign frame_bnd = i_valid && (i_sof || ((x_cnt == X_LAST) && (y_cnt == Y_LAST)));

  // Raster counters. They hold the position of the next valid pixel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (i_valid) begin
      if (i_sof) begin
        x_cnt <= P_W'(1);
        y_cnt <= '0;
      end else if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Shadow slot registers. Software writes these at any time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_en   <= '0;
      sh_mode <= '0;
      for (int s = 0; s < N_SLOT; s++) begin
        sh_glyph[s] <= '0;
        sh_x[s]     <= '0;
        sh_y[s]     <= '0;
      end
    end else if (cfg_we) begin
      sh_en[cfg_slot]    <= cfg_en;
      sh_mode[cfg_slot]  <= cfg_mode;
      sh_glyph[cfg_slot] <= cfg_glyph;
      sh_x[cfg_slot]     <= cfg_x;
      sh_y[cfg_slot]     <= cfg_y;
    end
  end

  // Active slots copy the shadows at a frame boundary. The copy uses the pre-edge shadow
  // values, so a write on the boundary cycle waits for the next boundary.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act_en   <= '0;
      act_mode <= '0;
      for (int s = 0; s < N_SLOT; s++) begin
        act_glyph[s] <= '0;
        act_x[s]     <= '0;
        act_y[s]     <= '0;
      end
    end else if (frame_bnd) begin
      act_en    <= sh_en;
      act_mode  <= sh_mode;
      act_glyph <= sh_glyph;
      act_x     <= sh_x;
      act_y     <= sh_y;
    end
  end

  // Slot hit test. The loop scans downwards so the lowest-index hit is the one that
  // remains. Compares are one bit wider so a glyph near coordinate max cannot wrap to 0.
  always_comb begin
    hit       = 1'b0;
    hit_mode  = 1'b0;
    hit_glyph = '0;
    hit_dx    = '0;
    hit_dy    = '0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      if (act_en[s] &&
          ({1'b0, px} >= {1'b0, act_x[s]}) && ({1'b0, px} < {1'b0, act_x[s]} + GW_EXT) &&
          ({1'b0, py} >= {1'b0, act_y[s]}) && ({1'b0, py} < {1'b0, act_y[s]} + GH_EXT)) begin
        hit       = 1'b1;
        hit_mode  = act_mode[s];
        hit_glyph = act_glyph[s];
        hit_dx    = XW'(px - act_x[s]);
        hit_dy    = YW'(py - act_y[s]);
      end
    end
  end

  // S1-S4: capture the hit result and form the ROM address. The flags and the pixel then
  // ride alongside the 2-cycle ROM read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_vld <= 1'b0; s1_hit <= 1'b0; s1_mode <= 1'b0; s1_dat <= '0;
      s1_glyph <= '0; s1_dx <= '0; s1_dy <= '0;
      s2_vld <= 1'b0; s2_hit <= 1'b0; s2_mode <= 1'b0; s2_dat <= '0; o_rom_ad <= '0;
      s3_vld <= 1'b0; s3_hit <= 1'b0; s3_mode <= 1'b0; s3_dat <= '0;
      s4_vld <= 1'b0; s4_hit <= 1'b0; s4_mode <= 1'b0; s4_dat <= '0;
    end else begin
      s1_vld <= i_valid; s1_hit <= hit; s1_mode <= hit_mode; s1_dat <= i_data;
      s1_glyph <= hit_glyph; s1_dx <= hit_dx; s1_dy <= hit_dy;
      s2_vld <= s1_vld; s2_hit <= s1_hit; s2_mode <= s1_mode; s2_dat <= s1_dat;
      o_rom_ad <= s1_hit ? {s1_glyph, s1_dy, s1_dx} : '0;
      s3_vld <= s2_vld; s3_hit <= s2_hit; s3_mode <= s2_mode; s3_dat <= s2_dat;
      s4_vld <= s3_vld; s4_hit <= s3_hit; s4_mode <= s3_mode; s4_dat <= s3_dat;
    end
  end

  // S5: combine the pixel with the glyph bit. Stencil paints paper where the bit is clear,
  // and overlay paints ink where the bit is set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= s4_vld;
      if (!s4_hit)
        o_data <= s4_dat;
      else if (s4_mode)
        o_data <= i_rom_bit ? FG_COLOR : s4_dat;
      else
        o_data <= i_rom_bit ? s4_dat : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_show_glyph_overlay.sv
// Bench for show_glyph_overlay on a reduced 136x114 image, with a behavioural 2-cycle glyph ROM.
// Every output pixel is scored against a slot model. Hand-computed pixel counts and probes
// pin down geometry, priority, commit timing and reset.
module tb_show_glyph_overlay;
  localparam int IMG_W = 136;
  localparam int IMG_H = 114;
  localparam logic [23:0] FG = 24'hFF0000;
  localparam logic [23:0] BG = 24'hFFFFFF;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        i_valid, i_sof;
  logic [23:0] i_data;
  logic        cfg_we, cfg_en, cfg_mode;
  logic [2:0]  cfg_slot, cfg_glyph;
  logic [11:0] cfg_x, cfg_y;
  logic [13:0] o_rom_ad;
  logic        i_rom_bit = 1'b0;
  logic        o_valid;
  logic [23:0] o_data;

  show_glyph_overlay #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_data(i_data), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
    .cfg_mode(cfg_mode), .cfg_glyph(cfg_glyph), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .o_rom_ad(o_rom_ad), .i_rom_bit(i_rom_bit), .o_valid(o_valid), .o_data(o_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Glyph ROM: mode 0 all zeros, mode 1 all ones, mode 2 bit = address LSB (odd dx).
  int          rom_mode = 0;
  logic [13:0] rom_q = '0;
  function automatic logic rom_f(input logic [13:0] a);
    if (rom_mode == 0) return 1'b0;
    if (rom_mode == 1) return 1'b1;
    return a[0];
  endfunction
  always @(posedge sys_clk) begin
    rom_q     <= o_rom_ad;
    i_rom_bit <= rom_f(rom_q);
  end

  typedef struct { bit v; int x; int y; logic [23:0] d; } ent_t;
  ent_t sb[$];

  bit sh_en[8], sh_mode[8], act_en[8], act_mode[8];
  int sh_glyph[8], sh_x[8], sh_y[8], act_glyph[8], act_x[8], act_y[8];

  int n_chk = 0, n_fail = 0;
  int pix_err, bg_cnt, fg_cnt, fg_line0, gap_cnt = 0;
  logic [23:0] seen [int];
  int          rom_seen [int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      sh_en[s] = 0; sh_mode[s] = 0; sh_glyph[s] = 0; sh_x[s] = 0; sh_y[s] = 0;
      act_en[s] = 0; act_mode[s] = 0; act_glyph[s] = 0; act_x[s] = 0; act_y[s] = 0;
    end
  endtask

  task automatic sb_clear();
    ent_t e;
    e.v = 0; e.x = -1; e.y = -1; e.d = '0;
    sb.delete();
    repeat (4) sb.push_back(e);
  endtask

  task automatic clr_stats();
    pix_err = 0; bg_cnt = 0; fg_cnt = 0; fg_line0 = 0;
    seen.delete(); rom_seen.delete();
  endtask

  // Drive one cycle and predict its output, then score the output due after this edge.
  task automatic pix(input bit v, input bit sof, input int px, input int py);
    ent_t e;
    int   win, addr;
    logic rb;
    logic [23:0] din;
    din = {8'h5A, 8'(py), 8'(px)};
    i_valid = v; i_sof = sof; i_data = din;
    e.v = v; e.x = px; e.y = py; e.d = din;
    win = -1;
    for (int s = 7; s >= 0; s--)
      if (act_en[s] && px >= act_x[s] && px < act_x[s] + 32 && py >= act_y[s] && py < act_y[s] + 64)
        win = s;
    if (win >= 0) begin
      addr = act_glyph[win] * 2048 + (py - act_y[win]) * 32 + (px - act_x[win]);
      rb   = rom_f(14'(addr));
      if (act_mode[win]) e.d = rb ? FG : din;
      else               e.d = rb ? din : BG;
    end
    sb.push_back(e);
    if (v && (sof || (px == IMG_W - 1 && py == IMG_H - 1)))
      for (int s = 0; s < 8; s++) begin
        act_en[s] = sh_en[s]; act_mode[s] = sh_mode[s]; act_glyph[s] = sh_glyph[s];
        act_x[s] = sh_x[s]; act_y[s] = sh_y[s];
      end
    if (cfg_we) begin
      sh_en[int'(cfg_slot)] = cfg_en; sh_mode[int'(cfg_slot)] = cfg_mode;
      sh_glyph[int'(cfg_slot)] = int'(cfg_glyph);
      sh_x[int'(cfg_slot)] = int'(cfg_x); sh_y[int'(cfg_slot)] = int'(cfg_y);
    end
    @(posedge sys_clk);
    #1;
    cfg_we = 0;
    if (sb[sb.size() - 2].v)
      rom_seen[sb[sb.size() - 2].y * 4096 + sb[sb.size() - 2].x] = int'(o_rom_ad);
    e = sb.pop_front();
    if (o_valid !== e.v) pix_err++;
    else if (e.v && o_data !== e.d) pix_err++;
    if (o_valid === 1'b1 && o_data === BG) bg_cnt++;
    if (o_valid === 1'b1 && o_data === FG) begin
      fg_cnt++;
      if (e.y == 0) fg_line0++;
    end
    if (e.v) seen[e.y * 4096 + e.x] = o_data;
  endtask

  task automatic stream(input int y0, input int nlines, input bit sof_first);
    for (int y = y0; y < y0 + nlines; y++)
      for (int x = 0; x < IMG_W; x++) begin
        pix(1, sof_first && y == y0 && x == 0, x, y);
        gap_cnt++;
        if (gap_cnt % 37 == 0) pix(0, 0, -1, -1);
      end
  endtask

  task automatic flush();
    repeat (6) pix(0, 0, -1, -1);
  endtask

  task automatic cfg_set(input int s, input bit en, input bit md, input int g, input int x, input int y);
    cfg_we = 1; cfg_slot = 3'(s); cfg_en = en; cfg_mode = md;
    cfg_glyph = 3'(g); cfg_x = 12'(x); cfg_y = 12'(y);
  endtask

  task automatic cfg_write(input int s, input bit en, input bit md, input int g, input int x, input int y);
    cfg_set(s, en, md, g, x, y);
    pix(0, 0, -1, -1);
  endtask

  initial begin
    i_valid = 0; i_sof = 0; i_data = '0;
    cfg_we = 0; cfg_slot = '0; cfg_en = 0; cfg_mode = 0; cfg_glyph = '0; cfg_x = '0; cfg_y = '0;
    sys_rst_n = 0;
    model_clear(); sb_clear(); clr_stats();
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_o_valid", 32'(o_valid), 32'd0);
    check_val("rst_o_data", 32'(o_data), 32'd0);
    check_val("rst_o_rom_ad", 32'(o_rom_ad), 32'd0);
    sys_rst_n = 1;

    // Frame A: pass-through with every slot off. Slot 0 is staged in the middle of the frame.
    stream(0, 60, 1);
    cfg_write(0, 1, 0, 2, 100, 50);
    stream(60, IMG_H - 60, 0);
    flush();
    check_val("pass_pix_err", pix_err, 0);
    check_val("pass_bg_cnt", bg_cnt, 0);

    // Frame B: the stencil commits at the raster wrap. The next setup is staged mid-frame.
    clr_stats();
    stream(0, 60, 0);
    cfg_write(0, 0, 0, 2, 100, 50);
    cfg_write(1, 1, 1, 5, IMG_W - 14, IMG_H - 28);
    cfg_write(2, 1, 1, 1, 4090, 0);
    stream(60, IMG_H - 60, 0);
    flush();
    check_val("sten_pix_err", pix_err, 0);
    check_val("sten_bg_cnt", bg_cnt, 2048);
    check_val("sten_rom_100_50", rom_seen[50 * 4096 + 100], 4096);
    check_val("sten_rom_101_51", rom_seen[51 * 4096 + 101], 4129);
    check_val("sten_rom_131_113", rom_seen[113 * 4096 + 131], 6143);
    check_val("sten_rom_99_50", rom_seen[50 * 4096 + 99], 0);
    check_val("sten_px_100_50", 32'(seen[50 * 4096 + 100]), 32'(BG));
    check_val("sten_px_132_113", 32'(seen[113 * 4096 + 132]), 32'h5A7184);

    // Frame C: an overlay clipped at the bottom-right corner. A slot at x=4090 must not wrap.
    rom_mode = 1;
    clr_stats();
    stream(0, IMG_H, 0);
    flush();
    check_val("clip_pix_err", pix_err, 0);
    check_val("clip_fg_cnt", fg_cnt, 392);
    check_val("clip_fg_line0", fg_line0, 0);
    check_val("clip_px_121_86", 32'(seen[86 * 4096 + 121]), 32'h5A5679);
    check_val("clip_px_135_113", 32'(seen[113 * 4096 + 135]), 32'(FG));

    // Frame D: slot 3 stencil overlaps slot 5 overlay, and slot 3 must win.
    cfg_write(1, 0, 0, 0, 0, 0);
    cfg_write(2, 0, 0, 0, 0, 0);
    cfg_write(3, 1, 0, 3, 40, 20);
    cfg_write(5, 1, 1, 4, 30, 10);
    rom_mode = 2;
    flush();
    clr_stats();
    stream(0, 30, 1);
    flush();
    check_val("prio_pix_err", pix_err, 0);
    check_val("prio_px_40_20", 32'(seen[20 * 4096 + 40]), 32'(BG));
    check_val("prio_px_41_20", 32'(seen[20 * 4096 + 41]), 32'h5A1429);
    check_val("prio_px_35_15", 32'(seen[15 * 4096 + 35]), 32'(FG));

    // Frames E/F/G use short sof-delimited frames. A mid-frame write shows in the next frame,
    // and a write on the sof cycle shows one frame later.
    cfg_write(3, 0, 0, 0, 0, 0);
    cfg_write(5, 0, 0, 0, 0, 0);
    rom_mode = 0;
    flush();
    clr_stats();
    stream(0, 4, 1);
    cfg_write(0, 1, 0, 0, 10, 1);
    stream(4, 4, 0);
    flush();
    check_val("commit_e_bg", bg_cnt, 0);
    check_val("commit_e_err", pix_err, 0);
    clr_stats();
    cfg_set(0, 1, 0, 0, 50, 3);
    stream(0, 8, 1);
    flush();
    check_val("commit_f_bg", bg_cnt, 224);
    check_val("commit_f_err", pix_err, 0);
    clr_stats();
    stream(0, 8, 1);
    flush();
    check_val("commit_g_bg", bg_cnt, 160);
    check_val("commit_g_err", pix_err, 0);

    // Reset mid-frame with pixels in flight and i_valid held high.
    stream(0, 2, 1);
    i_valid = 1; i_sof = 0; i_data = 24'h5A0000;
    sys_rst_n = 0;
    #1;
    check_val("midrst_o_valid", 32'(o_valid), 32'd0);
    check_val("midrst_o_data", 32'(o_data), 32'd0);
    check_val("midrst_o_rom_ad", 32'(o_rom_ad), 32'd0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    i_valid = 0;
    sys_rst_n = 1;
    model_clear(); sb_clear(); clr_stats();
    cfg_write(0, 1, 0, 2, 100, 50);
    stream(0, IMG_H, 0);
    flush();
    check_val("postrst_bg_off", bg_cnt, 0);
    check_val("postrst_err_a", pix_err, 0);
    clr_stats();
    stream(0, 60, 0);
    flush();
    check_val("postrst_bg_on", bg_cnt, 320);
    check_val("postrst_err_b", pix_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
